// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl
//   Fork/join sequencer. On start it launches a group of up to N_TASKS
//   parallel tasks, waits for them according to the captured join policy
//   (join_all / join_any / join_none), launches a single continuation, and
//   reports done once the continuation and every forked task have finished.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        one-cycle request to fork a group
//   mode         join policy, sampled with start (00 all, 01 any, 10 none, 11 all)
//   task_en      mask of tasks to launch, sampled with start
//   task_start   one-cycle launch pulse per enabled task
//   task_done    one-cycle completion pulse per task
//   next_start   one-cycle launch pulse of the continuation
//   next_done    one-cycle completion pulse of the continuation
//   pending      launched tasks not yet completed
//   busy         controller is not idle
//   done         one-cycle pulse when the whole group has completed
//   join_cycles  cycles spent waiting for the join of the last group (saturating)
//   err_busy     one-cycle pulse when start arrives while busy
module fork_join_ctrl #(
  parameter int N_TASKS = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [N_TASKS-1:0] task_en,
  output logic [N_TASKS-1:0] task_start,
  input  logic [N_TASKS-1:0] task_done,
  output logic               next_start,
  input  logic               next_done,
  output logic [N_TASKS-1:0] pending,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   join_cycles,
  output logic               err_busy
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_JOIN,
    RUN_NEXT,
    WAIT_NEXT
  } state_t;

  localparam logic [1:0] MODE_ANY  = 2'b01;
  localparam logic [1:0] MODE_NONE = 2'b10;

  state_t             state;
  logic [1:0]         mode_cap;
  logic [N_TASKS-1:0] mask_cap;
  logic               next_seen;

  // Pending set as it will look after this cycle's completions are retired.
  logic [N_TASKS-1:0] pending_after;
  logic               join_ok;
  logic               next_ok;

  assign pending_after = pending & ~task_done;

  // join_any fires on any completion of a still-pending task, or immediately
  // when nothing was launched. Everything else (00 and 11) is join_all.
  always_comb begin
    join_ok = 1'b0;
    if (mode_cap == MODE_ANY) begin
      join_ok = ((pending & task_done) != '0) || (pending == '0);
    end else begin
      join_ok = (pending_after == '0);
    end
  end

  // A next_done arriving together with the final task_done completes the
  // group in that same cycle.
  assign next_ok = (next_seen || next_done) && (pending_after == '0);

  assign busy = (state != IDLE);

  // done and err_busy are decisions about the current cycle's inputs, so they
  // are decoded combinationally; both are held low while reset is asserted.
  assign done     = rst_n && (state == WAIT_NEXT) && next_ok;
  assign err_busy = rst_n && start && busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      task_start  <= '0;
      next_start  <= '0;
      pending     <= '0;
      join_cycles <= '0;
      next_seen   <= 1'b0;
    end else begin
      task_start <= '0;
      next_start <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_cap    <= mode;
            mask_cap    <= task_en;
            join_cycles <= '0;
            next_seen   <= 1'b0;
            // Registered here so the pulse lines up with the LAUNCH cycle.
            task_start  <= task_en;
            state       <= LAUNCH;
          end
        end

        // task_done is ignored here: pending is loaded, not updated.
        LAUNCH: begin
          pending <= mask_cap;
          if (mode_cap == MODE_NONE) begin
            next_start <= 1'b1;
            state      <= RUN_NEXT;
          end else begin
            state <= WAIT_JOIN;
          end
        end

        // The exit cycle is counted as well.
        WAIT_JOIN: begin
          pending <= pending_after;
          if (join_cycles != '1) begin
            join_cycles <= join_cycles + CNT_W'(1);
          end
          if (join_ok) begin
            next_start <= 1'b1;
            state      <= RUN_NEXT;
          end
        end

        // Tasks left running by join_any / join_none keep retiring here.
        RUN_NEXT: begin
          pending <= pending_after;
          state   <= WAIT_NEXT;
        end

        WAIT_NEXT: begin
          pending <= pending_after;
          if (next_done) begin
            next_seen <= 1'b1;
          end
          if (next_ok) begin
            next_seen <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Bench for fork_join_ctrl. Each scenario task queues the output pulses it
// expects (kind, cycle relative to its start request, value); a monitor pops
// and compares them whenever the DUT raises a pulse. Counters and state are
// compared inline in the scenario tasks. A second instance with CNT_W=4
// shares all inputs and is inspected only for counter saturation.
module tb_fork_join_ctrl;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [N-1:0] task_en;
  logic [N-1:0] task_done;
  logic         next_done;

  logic [N-1:0] task_start, pending;
  logic         next_start, busy, done, err_busy;
  logic [15:0]  join_cycles;

  logic [N-1:0] task_start_s, pending_s;
  logic         next_start_s, busy_s, done_s, err_busy_s;
  logic [3:0]   join_cycles_s;

  always #5 clk = ~clk;

  fork_join_ctrl #(.N_TASKS(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .task_en(task_en),
    .task_start(task_start), .task_done(task_done), .next_start(next_start),
    .next_done(next_done), .pending(pending), .busy(busy), .done(done),
    .join_cycles(join_cycles), .err_busy(err_busy)
  );

  fork_join_ctrl #(.N_TASKS(N), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .task_en(task_en),
    .task_start(task_start_s), .task_done(task_done), .next_start(next_start_s),
    .next_done(next_done), .pending(pending_s), .busy(busy_s), .done(done_s),
    .join_cycles(join_cycles_s), .err_busy(err_busy_s)
  );

  typedef struct {
    int         kind;  // 0 task_start, 1 next_start, 2 done, 3 err_busy
    int         cyc;
    logic [7:0] val;
  } ev_t;

  ev_t   exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cur_t = -1;
  bit    mon_en = 1'b0;
  string kname[4] = '{"task_start", "next_start", "done", "err_busy"};

  // Drive one cycle's inputs just after the rising edge, return at the
  // falling edge so callers sample mid-cycle.
  task automatic drive(input int t, input logic s, input logic [1:0] m,
                       input logic [N-1:0] en, input logic [N-1:0] td,
                       input logic nd, input logic rn);
    @(posedge clk);
    #1;
    rst_n = rn; start = s; mode = m; task_en = en; task_done = td; next_done = nd;
    cur_t = t;
    @(negedge clk);
  endtask

  // Scoreboard monitor.
  logic [7:0] obs [4];
  bit         fire[4];
  ev_t        e;
  always @(negedge clk) begin
    if (mon_en) begin
      fire[0] = (task_start !== '0);   obs[0] = 8'(task_start);
      fire[1] = (next_start !== 1'b0); obs[1] = 8'(next_start);
      fire[2] = (done !== 1'b0);       obs[2] = 8'(done);
      fire[3] = (err_busy !== 1'b0);   obs[3] = 8'(err_busy);
      for (int k = 0; k < 4; k++) begin
        if (fire[k]) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_%s at cycle %0d: got %h, required no pulse",
                     kname[k], cur_t, obs[k]);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cur_t || e.val !== obs[k]) begin
              miscompares++;
              $display("FAIL event_%s: got %s=%h at cycle %0d, required %s=%h at cycle %0d",
                       kname[k], kname[k], obs[k], cur_t, kname[e.kind], e.val, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic push(input int k, input int c, input logic [7:0] v);
    ev_t x;
    x.kind = k; x.cyc = c; x.val = v;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    drive(-1, 1'b1, 2'b00, 2'b11, 2'b11, 1'b1, 1'b0);
    mon_en = 1'b1;
    drive(-1, 1'b1, 2'b00, 2'b11, 2'b11, 1'b1, 1'b0);
    vectors++;
    if (busy !== 1'b0 || pending !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b pending=%b, required busy=0 pending=00", busy, pending);
    end
    vectors++;
    if (task_start !== 2'b00 || next_start !== 1'b0 || done !== 1'b0 || err_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: task_start=%b next_start=%b done=%b err_busy=%b, required all 0",
               task_start, next_start, done, err_busy);
    end
    vectors++;
    if (join_cycles !== 16'd0 || join_cycles_s !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_join_cycles: got %0d/%0d, required 0/0", join_cycles, join_cycles_s);
    end
    drive(-1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_join_all();
    push(0, 1, 8'h03); push(1, 32, 8'h01); push(2, 35, 8'h01);
    for (int t = 0; t <= 36; t++) begin
      // Stray task_done[1] in the LAUNCH cycle must be ignored.
      drive(t, t == 0, (t == 0) ? 2'b00 : 2'b01, 2'b11,
            {(t == 1 || t == 31), (t == 21)}, t == 35, 1'b1);
      if (t == 2) begin
        vectors++;
        if (pending !== 2'b11) begin
          miscompares++;
          $display("FAIL all_pending_c2: got %b, required 11", pending);
        end
      end
      if (t == 22) begin
        vectors++;
        if (pending !== 2'b10) begin
          miscompares++;
          $display("FAIL all_pending_c22: got %b, required 10", pending);
        end
      end
      if (t == 32) begin
        vectors++;
        if (join_cycles !== 16'd30) begin
          miscompares++;
          $display("FAIL all_join_cycles: got %0d, required 30", join_cycles);
        end
      end
      if (t == 36) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL all_idle_after_done: busy=%b, required 0", busy);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL all_missing_events: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_join_any();
    push(0, 1, 8'h03); push(1, 22, 8'h01); push(2, 31, 8'h01);
    for (int t = 0; t <= 33; t++) begin
      drive(t, t == 0, (t == 0) ? 2'b01 : 2'b00, 2'b11,
            {(t == 31), (t == 21)}, t == 25, 1'b1);
      if (t == 22) begin
        vectors++;
        if (join_cycles !== 16'd20) begin
          miscompares++;
          $display("FAIL any_join_cycles: got %0d, required 20", join_cycles);
        end
      end
      if (t == 22 || t == 31) begin
        vectors++;
        if (pending !== 2'b10) begin
          miscompares++;
          $display("FAIL any_pending_c%0d: got %b, required 10", t, pending);
        end
      end
      if (t == 28) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL any_busy_c28: got %b, required 1", busy);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL any_missing_events: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_join_none();
    push(0, 1, 8'h03); push(1, 2, 8'h01); push(2, 31, 8'h01);
    for (int t = 0; t <= 33; t++) begin
      drive(t, t == 0, (t == 0) ? 2'b10 : 2'b00, 2'b11,
            {(t == 31), (t == 21)}, t == 5, 1'b1);
      if (t == 22) begin
        vectors++;
        if (pending !== 2'b10) begin
          miscompares++;
          $display("FAIL none_pending_c22: got %b, required 10", pending);
        end
      end
      if (t == 31) begin
        vectors++;
        if (join_cycles !== 16'd0) begin
          miscompares++;
          $display("FAIL none_join_cycles: got %0d, required 0", join_cycles);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL none_missing_events: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_empty_mask();
    push(1, 3, 8'h01); push(2, 6, 8'h01);
    for (int t = 0; t <= 8; t++) begin
      drive(t, t == 0, 2'b01, 2'b00, 2'b00, t == 6, 1'b1);
      if (t == 4) begin
        vectors++;
        if (join_cycles !== 16'd1 || pending !== 2'b00) begin
          miscompares++;
          $display("FAIL empty_join: join_cycles=%0d pending=%b, required 1 and 00",
                   join_cycles, pending);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL empty_missing_events: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_busy_reset();
    push(0, 1, 8'h03); push(3, 10, 8'h01);
    for (int t = 0; t <= 20; t++) begin
      drive(t, (t == 0 || t == 10 || t == 15), (t == 0) ? 2'b00 : 2'b01,
            (t == 0) ? 2'b11 : 2'b01,
            {(t == 15), (t == 12)}, t == 15, t != 15);
      if (t == 14) begin
        vectors++;
        if (pending !== 2'b10 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_capture_kept: pending=%b busy=%b, required 10 and 1", pending, busy);
        end
      end
      if (t == 16) begin
        vectors++;
        if (busy !== 1'b0 || pending !== 2'b00 || join_cycles !== 16'd0) begin
          miscompares++;
          $display("FAIL midrun_reset: busy=%b pending=%b join_cycles=%0d, required 0/00/0",
                   busy, pending, join_cycles);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL busy_missing_events: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    push(0, 1, 8'h01); push(1, 2, 8'h01); push(2, 5, 8'h01); push(3, 5, 8'h01);
    push(0, 7, 8'h02); push(1, 10, 8'h01); push(2, 14, 8'h01);
    for (int t = 0; t <= 16; t++) begin
      drive(t, (t == 0 || t == 5 || t == 6),
            (t == 0) ? 2'b10 : 2'b00,
            (t == 0) ? 2'b01 : ((t == 5) ? 2'b11 : 2'b10),
            {(t == 9), (t == 4)}, (t == 5 || t == 8 || t == 14), 1'b1);
      if (t == 10) begin
        vectors++;
        if (join_cycles !== 16'd2) begin
          miscompares++;
          $display("FAIL b2b_join_cycles: got %0d, required 2", join_cycles);
        end
      end
      if (t == 13) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_early_next_done_ignored: busy=%b, required 1", busy);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_missing_events: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_saturation();
    push(0, 1, 8'h03); push(1, 43, 8'h01); push(2, 44, 8'h01);
    for (int t = 0; t <= 45; t++) begin
      drive(t, t == 0, 2'b00, 2'b11, (t == 42) ? 2'b11 : 2'b00, t == 44, 1'b1);
      if (t == 16) begin
        vectors++;
        if (join_cycles_s !== 4'd14) begin
          miscompares++;
          $display("FAIL sat_count_c16: got %0d, required 14", join_cycles_s);
        end
      end
      if (t == 17 || t == 41 || t == 43) begin
        vectors++;
        if (join_cycles_s !== 4'd15) begin
          miscompares++;
          $display("FAIL sat_hold_c%0d: got %0d, required 15", t, join_cycles_s);
        end
      end
      if (t == 43) begin
        vectors++;
        if (join_cycles !== 16'd41) begin
          miscompares++;
          $display("FAIL sat_wide_count: got %0d, required 41", join_cycles);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sat_missing_events: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; task_en = '0; task_done = '0; next_done = 1'b0;
    test_reset();
    test_join_all();
    test_join_any();
    test_join_none();
    test_empty_mask();
    test_back_to_back();
    test_busy_reset();
    test_saturation();
    drive(-1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
